// File: rtl/chroni_pkg.sv
// chroni_pkg: shared widths and encodings for the VRAM arbiter.
package chroni_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RELEASE} state_t;
  typedef enum logic {VID, CPU} owner_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video, CPU and RAM signals of the VRAM arbiter.
interface vram_arbiter_if;
  import chroni_pkg::*;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rd_req;
  logic              vid_rd_ack;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_we;
  logic              cpu_req;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd_data;
  modport slave (
    input  vid_addr, vid_rd_req, cpu_addr, cpu_wr_data, cpu_we, cpu_req, mem_rd_data,
    output vid_rd_ack, vid_data, cpu_ack, cpu_rd_data, mem_addr, mem_wr_data, mem_we
  );
  modport master (
    output vid_addr, vid_rd_req, cpu_addr, cpu_wr_data, cpu_we, cpu_req, mem_rd_data,
    input  vid_rd_ack, vid_data, cpu_ack, cpu_rd_data, mem_addr, mem_wr_data, mem_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous 8K x 8 RAM between video reads and CPU accesses,
// video first, with a starvation bound that forces a CPU grant.
module vram_arbiter
  import chroni_pkg::*;
#(
  parameter int CPU_STARVE_MAX = 4
) (
  input logic           sys_clk,
  input logic           reset_n,
  vram_arbiter_if.slave bus
);
  state_t state, state_nx;
  owner_t owner, owner_nx;
  logic [2:0] starve, starve_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] wdata, wdata_nx, vdata, vdata_nx, cdata, cdata_nx;
  logic we, we_nx, vack, vack_nx, cack, cack_nx, cpu_win;
  assign bus.mem_addr    = addr;
  assign bus.mem_wr_data = wdata;
  assign bus.mem_we      = we;
  assign bus.vid_data    = vdata;
  assign bus.cpu_rd_data = cdata;
  assign bus.vid_rd_ack  = vack;
  assign bus.cpu_ack     = cack;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    starve_nx = starve;
    addr_nx = addr;
    wdata_nx = wdata;
    we_nx = we;
    vdata_nx = vdata;
    cdata_nx = cdata;
    vack_nx = 1'b0;
    cack_nx = 1'b0;
    cpu_win = bus.cpu_req && (!bus.vid_rd_req || starve == 3'(CPU_STARVE_MAX));
    case (state)
      IDLE: begin
        if (!bus.cpu_req) starve_nx = '0;
        if (bus.vid_rd_req || bus.cpu_req) begin
          state_nx = ACCESS;
          owner_nx = cpu_win ? CPU : VID;
          addr_nx = cpu_win ? bus.cpu_addr : bus.vid_addr;
          wdata_nx = cpu_win ? bus.cpu_wr_data : wdata;
          we_nx = cpu_win && bus.cpu_we;
          // only video grants made while the CPU waits count toward starvation
          if (bus.cpu_req) starve_nx = cpu_win ? 3'd0 : (starve == 3'd7 ? starve : starve + 3'd1);
        end
      end
      ACCESS: begin
        state_nx = CAPTURE;
        we_nx = 1'b0;
      end
      CAPTURE: begin
        state_nx = RELEASE;
        if (owner == CPU) begin
          cdata_nx = bus.mem_rd_data;
          cack_nx = 1'b1;
        end else begin
          vdata_nx = bus.mem_rd_data;
          vack_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= VID;
      starve <= '0;
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      vdata <= '0;
      cdata <= '0;
      vack <= 1'b0;
      cack <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      starve <= starve_nx;
      addr <= addr_nx;
      wdata <= wdata_nx;
      we <= we_nx;
      vdata <= vdata_nx;
      cdata <= cdata_nx;
      vack <= vack_nx;
      cack <= cack_nx;
    end
  end
endmodule
